// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking-lot controller.
// Holds the gate FSM encoding, default lot constants and helper functions.
package parking_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } gate_st_e;

    // Width of a counter that must reach n-1; never narrower than 1 bit.
    function automatic int hold_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Night wraps through midnight: [start, HOURS) plus [0, end).
    function automatic logic is_night(input logic [5:0] t,
                                      input int        s,
                                      input int        e);
        return (t >= 6'(s)) || (t < 6'(e));
    endfunction

    localparam int DEF_CAPACITY    = 8;
    localparam int DEF_HOURS       = 24;
    localparam int DEF_NIGHT_START = 23;
    localparam int DEF_NIGHT_END   = 6;
    localparam int DEF_GATE_HOLD   = 100_000_000;
    localparam int HOLD_W          = hold_w(DEF_GATE_HOLD);

endpackage

// File: rtl/parking_edge_detect.sv
// Rising-edge detector: one history flop plus an AND.
// Ports: clk, rst (async active-low), d (level in), rise (1-clk pulse out).
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/parking_ctrl.sv
// Parking-lot core: hour counter, free-space counter and barrier gate FSM.
// In: clk, rst (async low), power, hour_tick, enter_btn, exit_btn.
// Out: car, time_cnt, night, full, gate_open, reject (1-clk pulse).
module parking_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEF_CAPACITY,
    parameter int HOURS       = DEF_HOURS,
    parameter int NIGHT_START = DEF_NIGHT_START,
    parameter int NIGHT_END   = DEF_NIGHT_END,
    parameter int GATE_HOLD   = DEF_GATE_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       hour_tick,
    input  logic       enter_btn,
    input  logic       exit_btn,
    output logic [3:0] car,
    output logic [5:0] time_cnt,
    output logic       night,
    output logic       full,
    output logic       gate_open,
    output logic       reject
);

    localparam int              HW       = hold_w(GATE_HOLD);
    localparam logic [3:0]      CAP      = 4'(CAPACITY);
    localparam logic [5:0]      LAST_HR  = 6'(HOURS - 1);
    localparam logic [HW-1:0]   LAST_CNT = HW'(GATE_HOLD - 1);

    gate_st_e      state_q, state_d;
    logic [3:0]    car_q,   car_d;
    logic [5:0]    time_q,  time_d;
    logic [HW-1:0] cnt_q,   cnt_d;
    logic          night_q, night_d;
    logic          full_q,  full_d;
    logic          rej_q,   rej_d;
    logic          enter_rise;
    logic          exit_rise;

    // History flops keep sampling while power is off, so a button held
    // across power-up does not register as a fresh request.
    edge_detect u_enter (
        .clk  (clk),
        .rst  (rst),
        .d    (enter_btn),
        .rise (enter_rise)
    );

    edge_detect u_exit (
        .clk  (clk),
        .rst  (rst),
        .d    (exit_btn),
        .rise (exit_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            car_q   <= CAP;
            time_q  <= '0;
            cnt_q   <= '0;
            night_q <= 1'b1;
            full_q  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            car_q   <= car_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            night_q <= night_d;
            full_q  <= full_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d = state_q;
        car_d   = car_q;
        time_d  = time_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;

        if (power && hour_tick) begin
            time_d = (time_q == LAST_HR) ? '0 : time_q + 6'd1;
        end

        if (!power) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Exit has priority; a coincident enter edge is dropped.
                    // Policy uses night_q, i.e. the hour before this edge.
                    if (exit_rise) begin
                        if (car_q < CAP) begin
                            car_d   = car_q + 4'd1;
                            cnt_d   = '0;
                            state_d = ST_OPEN;
                        end
                    end else if (enter_rise) begin
                        if (!night_q && car_q != 4'd0) begin
                            car_d   = car_q - 4'd1;
                            cnt_d   = '0;
                            state_d = ST_OPEN;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                ST_OPEN: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + HW'(1);
                    end
                end
            endcase
        end

        // Flags follow the values being loaded this cycle: no extra lag.
        night_d = is_night(time_d, NIGHT_START, NIGHT_END);
        full_d  = (car_d == 4'd0);
    end

    always_comb begin
        car       = car_q;
        time_cnt  = time_q;
        night     = night_q;
        full      = full_q;
        gate_open = (state_q == ST_OPEN);
        reject    = rej_q;
    end

endmodule

// File: tb/tb_parking_ctrl.sv
// Self-checking bench for parking_ctrl with a 4-cycle gate hold.
// Directed table, hand sequences and random traffic against a lot model.
module tb_parking_ctrl;

    localparam int GH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power = 1'b0;
    logic       hour_tick = 1'b0;
    logic       enter_btn = 1'b0;
    logic       exit_btn = 1'b0;
    logic [3:0] car;
    logic [5:0] time_cnt;
    logic       night;
    logic       full;
    logic       gate_open;
    logic       reject;

    parking_ctrl #(.GATE_HOLD(GH)) dut (
        .clk       (clk),
        .rst       (rst),
        .power     (power),
        .hour_tick (hour_tick),
        .enter_btn (enter_btn),
        .exit_btn  (exit_btn),
        .car       (car),
        .time_cnt  (time_cnt),
        .night     (night),
        .full      (full),
        .gate_open (gate_open),
        .reject    (reject)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Lot model: free spaces, hour of day, remaining open cycles.
    int m_car;
    int m_hour;
    int m_left;
    bit m_rej;
    bit m_pen;
    bit m_pex;

    function automatic bit night_of(int h);
        return (h >= 23) || (h < 6);
    endfunction

    task automatic m_reset();
        m_car  = 8;
        m_hour = 0;
        m_left = 0;
        m_rej  = 0;
        m_pen  = 0;
        m_pex  = 0;
    endtask

    task automatic m_clock(bit p, bit t, bit e, bit x);
        bit ee, xe, was_night;
        ee        = e && !m_pen;
        xe        = x && !m_pex;
        was_night = night_of(m_hour);
        m_pen     = e;
        m_pex     = x;
        m_rej     = 0;
        if (!p) begin
            m_left = 0;
        end else begin
            if (t) m_hour = (m_hour + 1) % 24;
            if (m_left > 0) begin
                m_left--;
            end else if (xe) begin
                if (m_car < 8) begin
                    m_car++;
                    m_left = GH;
                end
            end else if (ee) begin
                if (!was_night && m_car > 0) begin
                    m_car--;
                    m_left = GH;
                end else begin
                    m_rej = 1;
                end
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, " car"}, int'(car), m_car);
        chk({tag, " time"}, int'(time_cnt), m_hour);
        chk({tag, " night"}, int'(night), int'(night_of(m_hour)));
        chk({tag, " full"}, int'(full), int'(m_car == 0));
        chk({tag, " gate"}, int'(gate_open), int'(m_left > 0));
        chk({tag, " reject"}, int'(reject), int'(m_rej));
    endtask

    task automatic step(bit p, bit t, bit e, bit x);
        power     = p;
        hour_tick = t;
        enter_btn = e;
        exit_btn  = x;
        @(posedge clk);
        m_clock(p, t, e, x);
        #1;
        chk_model("model");
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " car"}, int'(car), 8);
        chk({tag, " time"}, int'(time_cnt), 0);
        chk({tag, " night"}, int'(night), 1);
        chk({tag, " full"}, int'(full), 0);
        chk({tag, " gate"}, int'(gate_open), 0);
        chk({tag, " reject"}, int'(reject), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        power     = 1'b0;
        hour_tick = 1'b0;
        enter_btn = 1'b0;
        exit_btn  = 1'b0;
        #2;
        m_reset();
        chk_reset("reset");
        @(negedge clk);
        rst   = 1'b1;
        power = 1'b1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0);
    endtask

    task automatic enter_once();
        step(1, 0, 1, 0);
        repeat (GH + 1) step(1, 0, 0, 0);
    endtask

    task automatic exit_once();
        step(1, 0, 0, 1);
        repeat (GH + 1) step(1, 0, 0, 0);
    endtask

    typedef struct {
        bit en;
        bit ex;
        int car;
        int gate;
        int rej;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 0, 7, 1, 0};
        tbl[1]  = '{0, 0, 7, 1, 0};
        tbl[2]  = '{1, 0, 7, 1, 0};
        tbl[3]  = '{0, 0, 7, 1, 0};
        tbl[4]  = '{0, 0, 7, 0, 0};
        tbl[5]  = '{1, 1, 8, 1, 0};
        tbl[6]  = '{0, 0, 8, 1, 0};
        tbl[7]  = '{0, 0, 8, 1, 0};
        tbl[8]  = '{0, 0, 8, 1, 0};
        tbl[9]  = '{0, 0, 8, 0, 0};
        tbl[10] = '{0, 1, 8, 0, 0};
        tbl[11] = '{1, 0, 7, 1, 0};

        do_reset();

        // Hour counter through a full day.
        for (int i = 1; i <= 24; i++) begin
            step(1, 1, 0, 0);
            if (i == 6) begin
                chk("hr6 time", int'(time_cnt), 6);
                chk("hr6 night", int'(night), 0);
                chk("hr6 car", int'(car), 8);
                chk("hr6 gate", int'(gate_open), 0);
            end
            if (i == 23) begin
                chk("hr23 time", int'(time_cnt), 23);
                chk("hr23 night", int'(night), 1);
            end
            if (i == 24) begin
                chk("hr24 time", int'(time_cnt), 0);
                chk("hr24 night", int'(night), 1);
            end
        end

        // Gate timing, blocked entry while open, exit priority.
        ticks(10);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, tbl[i].en, tbl[i].ex);
            chk($sformatf("vec%0d car", i), int'(car), tbl[i].car);
            chk($sformatf("vec%0d gate", i), int'(gate_open), tbl[i].gate);
            chk($sformatf("vec%0d reject", i), int'(reject), tbl[i].rej);
            chk($sformatf("vec%0d night", i), int'(night), 0);
            chk($sformatf("vec%0d time", i), int'(time_cnt), 10);
        end
        repeat (GH + 1) step(1, 0, 0, 0);

        // Fill the lot, then one more entry is refused.
        do_reset();
        ticks(10);
        repeat (8) enter_once();
        chk("fill car", int'(car), 0);
        chk("fill full", int'(full), 1);
        step(1, 0, 1, 0);
        chk("over reject", int'(reject), 1);
        chk("over gate", int'(gate_open), 0);
        step(1, 0, 0, 0);
        chk("over reject end", int'(reject), 0);
        chk("over car", int'(car), 0);

        // Night refusal, then exits.
        ticks(16);
        chk("nt time", int'(time_cnt), 2);
        chk("nt night", int'(night), 1);
        step(1, 0, 1, 0);
        chk("nt reject", int'(reject), 1);
        chk("nt car", int'(car), 0);
        step(1, 0, 0, 0);
        repeat (5) exit_once();
        chk("ex5 car", int'(car), 5);
        step(1, 0, 0, 1);
        chk("ex6 car", int'(car), 6);
        chk("ex6 gate", int'(gate_open), 1);
        repeat (GH + 1) step(1, 0, 0, 0);

        // Simultaneous edges at car=4, day.
        ticks(8);
        enter_once();
        enter_once();
        chk("sim pre car", int'(car), 4);
        step(1, 0, 1, 1);
        chk("sim car", int'(car), 5);
        chk("sim reject", int'(reject), 0);
        repeat (GH + 1) step(1, 0, 0, 0);

        // Held button: one entry only.
        repeat (20) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("held car", int'(car), 4);

        // Power off mid-open.
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("pw open gate", int'(gate_open), 1);
        step(0, 1, 0, 0);
        chk("pw gate", int'(gate_open), 0);
        chk("pw time", int'(time_cnt), 10);
        chk("pw car", int'(car), 5);
        step(0, 1, 1, 0);
        chk("pw2 time", int'(time_cnt), 10);
        chk("pw2 reject", int'(reject), 0);
        step(1, 0, 1, 0);
        chk("pwup car", int'(car), 5);
        chk("pwup gate", int'(gate_open), 0);
        step(1, 0, 0, 0);

        // Async reset while open: outputs return without a clock edge.
        step(1, 0, 1, 0);
        chk("ar open", int'(gate_open), 1);
        step(1, 0, 0, 0);
        rst = 1'b0;
        #2;
        chk_reset("async");
        m_reset();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic.
        ticks(8);
        repeat (1500) begin
            step($urandom_range(0, 19) != 0,
                 ($urandom % 4) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
